// File: rtl/laser_pkg.sv
// -----------------------------------------------------------------------------
// laser_pkg
// Definitions shared by the laser driver and the laser receiver:
//   - lrx_state_t   : receiver state encoding (2 bits)
//   - LASER_TIMER_W : width of the receiver's cycle timer
//   - CLK_HZ        : default system clock frequency
//   - LASER_MAX_ON  : longest beam burst the driver can emit, in cycles
// -----------------------------------------------------------------------------
package laser_pkg;

    typedef enum logic [1:0] {
        LRX_IDLE     = 2'd0,
        LRX_QUALIFY  = 2'd1,
        LRX_HELD     = 2'd2,
        LRX_COOLDOWN = 2'd3
    } lrx_state_t;

    localparam int          LASER_TIMER_W = 32;
    localparam int unsigned CLK_HZ        = 32'd50000000;
    localparam int unsigned LASER_MAX_ON  = 32'd150000000;

endpackage : laser_pkg

// File: rtl/laser_rx_sync.sv
// -----------------------------------------------------------------------------
// laser_rx_sync
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high reset (both stages load RESET_VAL)
//   d     - asynchronous input
//   q     - synchronized output (two clock edges of latency)
// -----------------------------------------------------------------------------
module laser_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic stage1_r;

    // Two-stage shift; the first stage may go metastable, the second resolves it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage1_r <= RESET_VAL;
            q        <= RESET_VAL;
        end else begin
            stage1_r <= d;
            q        <= stage1_r;
        end
    end

endmodule : laser_rx_sync

// File: rtl/laser_receiver.sv
// -----------------------------------------------------------------------------
// laser_receiver
// Target-side laser hit detector. The photodiode comparator output is
// synchronized, a beam lasting MIN_HIT_CYCLES+1 consecutive sampled cycles is
// qualified as a hit, and the detector then waits for beam loss followed by a
// COOLDOWN_CYCLES re-arm period before it can score again.
//
// Optional feature (macro LASER_RX_STUCK_DET_EN): flags `stuck` when the beam
// stays on for STUCK_CYCLES cycles after a hit. Without the macro, stuck is 0.
//
// Ports:
//   clock       - system clock
//   reset       - asynchronous, active-high reset
//   sensor_n    - raw photodiode comparator, 0 = beam present (asynchronous)
//   enable      - 1 = detector armed; 0 returns to IDLE on the next edge
//   clear_count - synchronous clear of hit_count
//   hit         - one-cycle pulse per qualified hit
//   hit_count   - saturating hit total
//   beam        - synchronized beam-present level
//   busy        - state is not IDLE
//   stuck       - beam held too long after a hit
// -----------------------------------------------------------------------------
module laser_receiver
    import laser_pkg::*;
#(
    parameter int unsigned MIN_HIT_CYCLES  = CLK_HZ / 32'd1000,
    parameter int unsigned COOLDOWN_CYCLES = CLK_HZ / 32'd2,
    parameter int unsigned CNT_W           = 8,
    // Longest legal driver burst plus one second of margin.
    parameter int unsigned STUCK_CYCLES    = LASER_MAX_ON + CLK_HZ
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sensor_n,
    input  logic             enable,
    input  logic             clear_count,
    output logic             hit,
    output logic [CNT_W-1:0] hit_count,
    output logic             beam,
    output logic             busy,
    output logic             stuck
);

`ifdef LASER_RX_STUCK_DET_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif

    localparam logic [LASER_TIMER_W-1:0] TIMER_ZERO = {LASER_TIMER_W{1'b0}};
    localparam logic [LASER_TIMER_W-1:0] TIMER_ONE  = LASER_TIMER_W'(32'd1);
    localparam logic [LASER_TIMER_W-1:0] MIN_T      = LASER_TIMER_W'(MIN_HIT_CYCLES);
    localparam logic [LASER_TIMER_W-1:0] COOL_LAST  = LASER_TIMER_W'(COOLDOWN_CYCLES - 32'd1);
    localparam logic [LASER_TIMER_W-1:0] STUCK_T    = LASER_TIMER_W'(STUCK_CYCLES);
    // The stuck flag rises on the edge where the timer arrives at STUCK_T.
    localparam logic [LASER_TIMER_W-1:0] STUCK_LAST =
        (STUCK_CYCLES > 32'd0) ? LASER_TIMER_W'(STUCK_CYCLES - 32'd1) : TIMER_ZERO;
    localparam logic [CNT_W-1:0]         CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]         CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]         CNT_MAX    = {CNT_W{1'b1}};

    logic                     sync_q_s;
    logic                     beam_s;
    logic                     qual_hit_s;
    lrx_state_t               state_r;
    logic [LASER_TIMER_W-1:0] timer_r;
    logic                     hit_r;
    logic [CNT_W-1:0]         count_r;
    logic                     stuck_r;

    // Reset value 1 = no beam, so beam reads 0 straight out of reset.
    laser_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (sensor_n),
        .q     (sync_q_s)
    );

    assign beam_s = ~sync_q_s;

    // Edge on which a qualification completes; drives both hit and the counter.
    assign qual_hit_s = enable && (state_r == LRX_QUALIFY) && beam_s && (timer_r == MIN_T);

    // Detector FSM with its timer and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= LRX_IDLE;
            timer_r <= TIMER_ZERO;
            hit_r   <= 1'b0;
            count_r <= CNT_ZERO;
            stuck_r <= 1'b0;
        end else begin
            hit_r   <= 1'b0;
            stuck_r <= 1'b0;

            if (!enable) begin
                state_r <= LRX_IDLE;
                timer_r <= TIMER_ZERO;
            end else begin
                case (state_r)
                    LRX_IDLE: begin
                        if (beam_s) begin
                            state_r <= LRX_QUALIFY;
                            timer_r <= TIMER_ONE;
                        end else begin
                            timer_r <= TIMER_ZERO;
                        end
                    end
                    LRX_QUALIFY: begin
                        if (!beam_s) begin
                            // Too short: treated as a glitch, nothing counted.
                            state_r <= LRX_IDLE;
                            timer_r <= TIMER_ZERO;
                        end else if (timer_r == MIN_T) begin
                            hit_r   <= 1'b1;
                            state_r <= LRX_HELD;
                            timer_r <= TIMER_ZERO;
                        end else begin
                            timer_r <= timer_r + TIMER_ONE;
                        end
                    end
                    LRX_HELD: begin
                        if (!beam_s) begin
                            state_r <= LRX_COOLDOWN;
                            timer_r <= TIMER_ZERO;
                        end else if (STUCK_EN) begin
                            // Timer parks at STUCK_T so the flag stays up while held.
                            if (timer_r >= STUCK_LAST) begin
                                timer_r <= STUCK_T;
                                stuck_r <= 1'b1;
                            end else begin
                                timer_r <= timer_r + TIMER_ONE;
                            end
                        end else begin
                            timer_r <= TIMER_ZERO;
                        end
                    end
                    LRX_COOLDOWN: begin
                        // Beam is ignored here; only elapsed time matters.
                        if (timer_r == COOL_LAST) begin
                            state_r <= LRX_IDLE;
                            timer_r <= TIMER_ZERO;
                        end else begin
                            timer_r <= timer_r + TIMER_ONE;
                        end
                    end
                    default: begin
                        state_r <= LRX_IDLE;
                        timer_r <= TIMER_ZERO;
                    end
                endcase
            end

            // A clear on the qualifying edge keeps that hit.
            if (clear_count) begin
                count_r <= qual_hit_s ? CNT_ONE : CNT_ZERO;
            end else if (qual_hit_s && (count_r != CNT_MAX)) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign hit       = hit_r;
    assign hit_count = count_r;
    assign beam      = beam_s;
    assign busy      = (state_r != LRX_IDLE);
    assign stuck     = stuck_r;

endmodule : laser_receiver

// File: tb/tb_laser_receiver.sv
module tb_laser_receiver;

    localparam int M   = 4;
    localparam int C   = 8;
    localparam int CW  = 3;
    localparam int ST  = 20;
    localparam int MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          sensor_n;
    logic          enable;
    logic          clear_count;
    logic          hit;
    logic [CW-1:0] hit_count;
    logic          beam;
    logic          busy;
    logic          stuck;

    laser_receiver #(
        .MIN_HIT_CYCLES  (M),
        .COOLDOWN_CYCLES (C),
        .CNT_W           (CW),
        .STUCK_CYCLES    (ST)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sensor_n    (sensor_n),
        .enable      (enable),
        .clear_count (clear_count),
        .hit         (hit),
        .hit_count   (hit_count),
        .beam        (beam),
        .busy        (busy),
        .stuck       (stuck)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 qualifying, 2 holding after hit, 3 cooling down.
    int m_mode;
    int m_seen;       // consecutive beam edges seen while qualifying
    int m_cool_left;  // edges remaining before re-arming
    int m_held;       // edges spent with beam held after a hit (capped)
    int m_count;
    bit m_hit;
    bit m_beam;
    bit m_last;       // sensor_n as sampled on the previous edge
    bit m_stuck;

    task automatic model_reset();
        m_mode = 0; m_seen = 0; m_cool_left = 0; m_held = 0; m_count = 0;
        m_hit = 1'b0; m_beam = 1'b0; m_last = 1'b1; m_stuck = 1'b0;
    endtask

    task automatic model_edge();
        bit b;
        b = m_beam;
        m_hit = 1'b0;
        if (!enable) begin
            m_mode = 0; m_seen = 0; m_held = 0; m_cool_left = 0;
        end else begin
            case (m_mode)
                0: if (b) begin m_mode = 1; m_seen = 1; end
                1: begin
                    if (!b) m_mode = 0;
                    else if (m_seen == M) begin m_hit = 1'b1; m_mode = 2; m_held = 0; end
                    else m_seen++;
                end
                2: begin
                    if (!b) begin m_mode = 3; m_cool_left = C; end
                    else if (m_held < ST) m_held++;
                end
                3: begin
                    m_cool_left--;
                    if (m_cool_left == 0) m_mode = 0;
                end
                default: m_mode = 0;
            endcase
        end
`ifdef LASER_RX_STUCK_DET_EN
        m_stuck = (m_mode == 2) && (m_held >= ST);
`else
        m_stuck = 1'b0;
`endif
        if (clear_count) m_count = m_hit ? 1 : 0;
        else if (m_hit && m_count < MAXC) m_count++;
        m_beam = !m_last;
        m_last = sensor_n;
    endtask

    task automatic compare_all();
        check_eq("hit",       32'(hit),       32'(m_hit));
        check_eq("hit_count", 32'(hit_count), 32'(m_count));
        check_eq("beam",      32'(beam),      32'(m_beam));
        check_eq("busy",      32'(busy),      32'(m_mode != 0));
        check_eq("stuck",     32'(stuck),     32'(m_stuck));
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int hit_edge;
    int n_hits;

    initial begin
        reset = 1'b0; sensor_n = 1'b1; enable = 1'b1; clear_count = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check_eq("reset_count", 32'(hit_count), 32'd0);
        step();
        step();
        reset = 1'b0;
        run(3);

        // Qualify: continuous beam from edge 0, hit after edge 6.
        sensor_n = 1'b0; hit_edge = -1; n_hits = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (hit) begin n_hits++; hit_edge = i; end
        end
        check_eq("qual_edge",  32'(hit_edge), 32'd6);
        check_eq("qual_nhits", 32'(n_hits),   32'd1);
        sensor_n = 1'b1;
        run(14);
        check_eq("qual_idle", 32'(busy), 32'd0);

        // Glitch: three low samples, no hit.
        sensor_n = 1'b0;
        run(3);
        sensor_n = 1'b1;
        run(6);
        check_eq("glitch_count", 32'(hit_count), 32'd1);

        // Cooldown: brief loss, beam back during cooldown, held through its end.
        sensor_n = 1'b0;
        run(8);
        sensor_n = 1'b1;
        run(2);
        sensor_n = 1'b0;
        run(20);
        check_eq("requal_count", 32'(hit_count), 32'd3);
        sensor_n = 1'b1;
        run(14);

        // Saturation.
        for (int p = 0; p < 9; p++) begin
            sensor_n = 1'b0; run(7);
            sensor_n = 1'b1; run(12);
        end
        check_eq("sat_count", 32'(hit_count), 32'd7);

        // Clear on the qualifying edge keeps the hit.
        sensor_n = 1'b0;
        for (int i = 0; i < 7; i++) begin
            clear_count = (i == 6);
            step();
        end
        clear_count = 1'b0;
        check_eq("clr_hit_count", 32'(hit_count), 32'd1);
        sensor_n = 1'b1; run(12);
        clear_count = 1'b1; step(); clear_count = 1'b0;
        check_eq("clr_alone_count", 32'(hit_count), 32'd0);

        // Abort via enable at QUALIFY timer=3.
        sensor_n = 1'b0;
        run(5);
        enable = 1'b0;
        step();
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_hit",  32'(hit),  32'd0);
        enable = 1'b1;
        run(3);
        // Asynchronous reset mid-qualify.
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_busy", 32'(busy), 32'd0);
        run(2);
        reset = 1'b0; sensor_n = 1'b1;
        run(4);

        // Long hold after a hit (stuck path when the feature is built in).
        sensor_n = 1'b0; run(40);
        sensor_n = 1'b1; run(14);

        // Randomized bursts.
        for (int s = 0; s < 60; s++) begin
            int on_len;
            int off_len;
            on_len  = int'($urandom_range(1, 14));
            off_len = int'($urandom_range(1, 20));
            for (int i = 0; i < on_len + off_len; i++) begin
                sensor_n    = (i >= on_len);
                enable      = ($urandom_range(0, 11) != 0);
                clear_count = ($urandom_range(0, 15) == 0);
                step();
            end
        end
        enable = 1'b1; clear_count = 1'b0; sensor_n = 1'b1;
        run(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_laser_receiver
